// File: rtl/mult_seq_if.sv
// Handshake and external-adder bundle for the sequential shift-add multiplier.
// The master modport is the requester; slave is the controller; adder is the external ripple adder.
interface mult_seq_if #(
  parameter int N = 16
);
  logic           start;
  logic           clr;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic           add_cin;
  logic [N-1:0]   add_s;
  logic           add_cout;

  modport master (
    output start, clr, mcand, mplier,
    input  busy, done, product
  );

  modport slave (
    input  start, clr, mcand, mplier, add_s, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );

  modport adder (
    input  add_a, add_b, add_cin,
    output add_s, add_cout
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Unsigned N x N -> 2N shift-add multiplier controller that time-shares one external
// N-bit adder over N CALC cycles, then pulses done for one cycle.
module mult_seq_ctrl #(
  parameter int N = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  mult_seq_if.slave bus
);
  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  m_reg, m_next;
  logic [N-1:0]  p_hi_reg, p_hi_next;
  logic [N-1:0]  p_lo_reg, p_lo_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          in_calc;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      p_hi_reg  <= '0;
      p_lo_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      p_hi_reg  <= p_hi_next;
      p_lo_reg  <= p_lo_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A new request can land both in IDLE and in DONE, giving back-to-back multiplies.
  assign accept = bus.start && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    p_hi_next  = p_hi_reg;
    p_lo_next  = p_lo_reg;
    cnt_next   = cnt_reg;
    if (bus.clr) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (accept) begin
      state_next = CALC;
      m_next     = bus.mcand;
      p_hi_next  = '0;
      p_lo_next  = bus.mplier;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        CALC: begin
          // Carry-out becomes the new MSB, so the shifted product never overflows.
          {p_hi_next, p_lo_next} = {bus.add_cout, bus.add_s, p_lo_reg[N-1:1]};
          cnt_next               = cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign in_calc     = (state_reg == CALC);
  assign bus.busy    = in_calc;
  assign bus.done    = (state_reg == DONE);
  assign bus.product = {p_hi_reg, p_lo_reg};
  assign bus.add_a   = in_calc ? p_hi_reg : '0;
  assign bus.add_cin = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_add_b
      assign bus.add_b[gi] = in_calc & p_lo_reg[0] & m_reg[gi];
    end
  endgenerate
endmodule
